// File: rtl/chal_pkg.sv
// Shared definitions for the challenge sequencer and the CMAC verifier.
// Holds the sequencer state encoding and the default challenge geometry.
package chal_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } chal_state_t;

    localparam int CHAL_W_DEF = 64;
    localparam int BYTE_W_DEF = 8;

endpackage

// File: rtl/challenge_tx_ctrl.sv
// Requests a challenge from the ASG generator, latches it, and streams it
// MSB byte first over a valid/ready handshake; holds it for the CMAC verifier.
module challenge_tx_ctrl
    import chal_pkg::*;
#(
    parameter int CHAL_W         = CHAL_W_DEF,
    parameter int BYTE_W         = BYTE_W_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              enable_sample,
    input  logic              sampled_done,
    input  logic [CHAL_W-1:0] rng_challenge,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CHAL_W-1:0] challenge,
    output logic              challenge_valid,
    output logic              busy,
    output logic              timeout_err,
    output chal_state_t       dbg_state
);

    localparam int NB    = CHAL_W / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Handshake: a byte transfers on any cycle where tx_valid && tx_ready;
    // tx_valid and tx_data are registered and never depend on tx_ready combinationally.

    chal_state_t       r_state;
    chal_state_t       w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [CNT_W-1:0]  r_cnt;
    logic [CHAL_W-1:0] r_challenge;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_next_byte;
    logic              r_tx_valid;
    logic              r_enable_sample;
    logic              r_challenge_valid;
    logic              r_busy;
    logic              r_timeout_err;
    logic              w_hs;
    logic              w_capture;
    logic              w_wait_exp;

    assign w_hs        = (r_state == SEND) && r_tx_valid && tx_ready;
    assign w_capture   = (r_state == WAIT) && sampled_done;
    // sampled_done has priority over an expiring counter.
    assign w_wait_exp  = (r_state == WAIT) && !sampled_done && (r_cnt == CNT_LAST);
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_next_byte = r_challenge[CHAL_W-1-BYTE_W*int'(w_idx_inc) -: BYTE_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = REQ;
            REQ:     w_next_state = WAIT;
            WAIT: begin
                if (sampled_done) begin
                    w_next_state = SEND;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = IDLE;
                end
            end
            SEND:    if (w_hs && (r_idx == LAST_IDX)) w_next_state = DONE;
            DONE:    if (start) w_next_state = REQ;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable_sample   <= 1'b0;
            r_busy            <= 1'b0;
            r_challenge_valid <= 1'b0;
            r_timeout_err     <= 1'b0;
            r_cnt             <= '0;
            r_idx             <= '0;
            r_challenge       <= '0;
            r_tx_data         <= '0;
            r_tx_valid        <= 1'b0;
        end else begin
            r_enable_sample   <= (w_next_state == REQ);
            r_busy            <= (w_next_state == REQ) || (w_next_state == WAIT) ||
                                 (w_next_state == SEND);
            r_challenge_valid <= (w_next_state == DONE);
            r_timeout_err     <= w_wait_exp;

            if (r_state == REQ) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_challenge <= rng_challenge;
                r_idx       <= '0;
                r_tx_data   <= rng_challenge[CHAL_W-1 -: BYTE_W];
                r_tx_valid  <= 1'b1;
            end else if (w_hs) begin
                if (r_idx == LAST_IDX) begin
                    r_tx_valid <= 1'b0;
                end else begin
                    r_idx     <= w_idx_inc;
                    r_tx_data <= w_next_byte;
                end
            end
        end
    end

    assign enable_sample   = r_enable_sample;
    assign tx_data         = r_tx_data;
    assign tx_valid        = r_tx_valid;
    assign challenge       = r_challenge;
    assign challenge_valid = r_challenge_valid;
    assign busy            = r_busy;
    assign timeout_err     = r_timeout_err;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_challenge_tx_ctrl.sv
// Directed bench for challenge_tx_ctrl with a fixed-latency generator model.
module tb_challenge_tx_ctrl;
    import chal_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        enable_sample;
    logic        sampled_done;
    logic [63:0] rng_challenge;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] challenge;
    logic        challenge_valid;
    logic        busy;
    logic        timeout_err;
    chal_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    int gen_cnt = 0;
    bit gen_on  = 1'b1;

    challenge_tx_ctrl #(.CHAL_W(64), .BYTE_W(8), .TIMEOUT_CYCLES(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .enable_sample   (enable_sample),
        .sampled_done    (sampled_done),
        .rng_challenge   (rng_challenge),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .challenge       (challenge),
        .challenge_valid (challenge_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: sampled_done high 65 cycles after the enable_sample cycle.
    always @(negedge clk) begin
        sampled_done = 1'b0;
        if (reset) begin
            gen_cnt = 0;
        end else begin
            if (gen_cnt > 0) begin
                gen_cnt = gen_cnt - 1;
                if (gen_cnt == 0) sampled_done = gen_on;
            end
            if (enable_sample) gen_cnt = 65;
        end
    end

    // Driver: pulses start in cycle 0, then runs until challenge_valid or stop_after bytes.
    task automatic run_stream(input logic [63:0] chal, input int ready_mode, input bit spam,
                              input int stop_after, output int first_v, output int cv_cyc,
                              output int en_cnt, output int stalls, output logic cv_c1);
        int k;
        bit prev_stall;
        logic [7:0] prev_data;
        first_v = -1; cv_cyc = -1; en_cnt = 0; stalls = 0; cv_c1 = 1'bx;
        k = 0; prev_stall = 0; prev_data = '0;
        got_q.delete();
        @(negedge clk);
        rng_challenge = chal;
        start = 1'b1;
        tx_ready = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = spam && (cyc <= 74);
            if (ready_mode == 0) tx_ready = 1'b1;
            else tx_ready = tx_valid && ((k % 4 == 0) || (k % 4 == 3));
            if (cyc == 1) cv_c1 = challenge_valid;
            if (enable_sample) en_cnt++;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stalls++;
            prev_stall = 0;
            if (tx_valid) begin
                if (first_v < 0) first_v = cyc;
                if (tx_ready) got_q.push_back(tx_data);
                else begin prev_stall = 1; prev_data = tx_data; end
                k++;
            end
            if (stop_after > 0 && got_q.size() == stop_after) break;
            if (challenge_valid) begin cv_cyc = cyc; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0; rng_challenge = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({enable_sample, tx_valid, busy, timeout_err, challenge_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000",
                {enable_sample, tx_valid, busy, timeout_err, challenge_valid});
        end
        checks++;
        if (tx_data !== 8'h00 || challenge !== 64'h0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 00/0", tx_data, challenge);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int tcnt, tcyc, vcnt;
        tcnt = 0; tcyc = -1; vcnt = 0;
        gen_on = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (timeout_err) begin tcnt++; if (tcyc < 0) tcyc = cyc; end
            if (tx_valid) vcnt++;
        end
        checks++;
        if (tcnt !== 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", tcnt); end
        checks++;
        if (tcyc !== 258) begin errors++; $display("FAIL timeout_cycle got %0d exp 258", tcyc); end
        checks++;
        if (challenge !== 64'h0) begin
            errors++; $display("FAIL timeout_chal got %h exp 0", challenge);
        end
        checks++;
        if (dbg_state !== IDLE || busy !== 1'b0 || vcnt !== 0) begin
            errors++; $display("FAIL timeout_idle got st=%0d busy=%b v=%0d exp 0/0/0",
                dbg_state, busy, vcnt);
        end
        gen_on = 1'b1;
    endtask

    task automatic test_basic;
        int fv, cv, en, st; logic c1;
        exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        run_stream(64'h0123_4567_89AB_CDEF, 0, 0, 0, fv, cv, en, st, c1);
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL basic_bytes got %p exp %p", got_q, exp_q);
        end
        checks++;
        if (fv !== 67) begin errors++; $display("FAIL basic_first_valid got %0d exp 67", fv); end
        checks++;
        if (cv !== 75) begin errors++; $display("FAIL basic_cv_cycle got %0d exp 75", cv); end
        checks++;
        if (en !== 1) begin errors++; $display("FAIL basic_enable got %0d exp 1", en); end
        checks++;
        if (challenge !== 64'h0123_4567_89AB_CDEF || busy !== 1'b0) begin
            errors++; $display("FAIL basic_chal got %h busy %b exp 0123456789abcdef 0",
                challenge, busy);
        end
    endtask

    task automatic test_stall;
        int fv, cv, en, st; logic c1;
        exp_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        run_stream(64'h0123_4567_89AB_CDEF, 1, 0, 0, fv, cv, en, st, c1);
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("FAIL stall_bytes got %p exp %p", got_q, exp_q);
        end
        checks++;
        if (st !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", st); end
        checks++;
        if (cv !== 83) begin errors++; $display("FAIL stall_cv_cycle got %0d exp 83", cv); end
    endtask

    task automatic test_start_ignored;
        int fv, cv, en, st; logic c1;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_stream(64'h1122_3344_5566_7788, 0, 1, 0, fv, cv, en, st, c1);
        checks++;
        if (en !== 1) begin errors++; $display("FAIL spam_enable got %0d exp 1", en); end
        checks++;
        if (got_q !== exp_q || cv !== 75) begin
            errors++; $display("FAIL spam_stream got %p cv %0d exp %p cv 75", got_q, cv, exp_q);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== DONE || enable_sample !== 1'b0 || challenge_valid !== 1'b1) begin
            errors++; $display("FAIL spam_done got st=%0d en=%b cv=%b exp %0d 0 1",
                dbg_state, enable_sample, challenge_valid, DONE);
        end
    endtask

    task automatic test_reset_mid;
        int fv, cv, en, st; logic c1;
        run_stream(64'h0123_4567_89AB_CDEF, 0, 0, 4, fv, cv, en, st, c1);
        checks++;
        if (got_q.size() !== 4 || got_q[3] !== 8'h67) begin
            errors++; $display("FAIL mid_partial got %p exp 01 23 45 67", got_q);
        end
        @(negedge clk);
        reset = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({enable_sample, tx_valid, busy, timeout_err, challenge_valid} !== 5'b0 ||
            tx_data !== 8'h00 || challenge !== 64'h0 || dbg_state !== IDLE) begin
            errors++; $display("FAIL mid_reset got %b %h %h st=%0d exp zeros",
                {enable_sample, tx_valid, busy, timeout_err, challenge_valid},
                tx_data, challenge, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_stream(64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, fv, cv, en, st, c1);
        checks++;
        if (got_q !== exp_q || cv !== 75) begin
            errors++; $display("FAIL mid_fresh got %p cv %0d exp %p cv 75", got_q, cv, exp_q);
        end
    endtask

    task automatic test_done_restart;
        int fv, cv, en, st; logic c1;
        exp_q = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
        run_stream(64'hFFFF_0000_A5A5_5A5A, 0, 0, 0, fv, cv, en, st, c1);
        checks++;
        if (c1 !== 1'b0) begin errors++; $display("FAIL restart_cv_drop got %b exp 0", c1); end
        checks++;
        if (got_q !== exp_q || cv !== 75) begin
            errors++; $display("FAIL restart_bytes got %p cv %0d exp %p cv 75", got_q, cv, exp_q);
        end
        checks++;
        if (challenge !== 64'hFFFF_0000_A5A5_5A5A) begin
            errors++; $display("FAIL restart_chal got %h exp ffff0000a5a55a5a", challenge);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_done_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
